// File: rtl/set_bit_serializer_if.sv
// Handshake bundle for the set-bit serializer: word input channel and
// per-bit output beat channel. The serializer is the slave; the block that
// feeds words and consumes beats is the master.
interface set_bit_serializer_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = $clog2(DATA_W)
);
   logic [DATA_W-1:0] data_i;
   logic              data_val_i;
   logic              data_ready_o;
   logic [DATA_W-1:0] bit_mask_o;
   logic [IDX_W-1:0]  bit_idx_o;
   logic              bit_last_o;
   logic              bit_empty_o;
   logic              bit_val_o;
   logic              bit_ready_i;

   modport master (
      output data_i, data_val_i, bit_ready_i,
      input  data_ready_o, bit_mask_o, bit_idx_o, bit_last_o, bit_empty_o, bit_val_o
   );

   modport slave (
      input  data_i, data_val_i, bit_ready_i,
      output data_ready_o, bit_mask_o, bit_idx_o, bit_last_o, bit_empty_o, bit_val_o
   );
endinterface

// File: rtl/set_bit_serializer.sv
// Set-bit serializer: takes one word per handshake and walks its set bits in
// priority order, one beat per bit (mask + index), by repeatedly isolating
// the top-priority bit of a residual register and clearing it once emitted.
// An all-zero word produces a single empty beat.
module set_bit_serializer #(
   parameter int DATA_W    = 16,
   parameter bit MSB_FIRST = 1'b0,
   parameter int IDX_W     = $clog2(DATA_W)
) (
   input logic                  clk_i,
   input logic                  srst_i,
   set_bit_serializer_if.slave  bus
);

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] residual;
   logic [DATA_W-1:0] residual_next;
   logic              empty_q;
   logic              empty_next;

   logic [DATA_W-1:0] ordered;
   logic [DATA_W-1:0] lowest;
   logic [DATA_W-1:0] beat_mask;
   logic [IDX_W-1:0]  beat_idx;
   logic              beat_last;
   logic              beat_valid;
   logic              transfer;
   logic              accept;

   function automatic logic [DATA_W-1:0] reverse_bits(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W; i++) begin
         r[i] = v[DATA_W-1-i];
      end
      return r;
   endfunction

   // High-priority-first is handled by mirroring the residual, isolating its
   // lowest set bit with the two's-complement trick, and mirroring back.
   assign ordered   = MSB_FIRST ? reverse_bits(residual) : residual;
   assign lowest    = ordered & (~ordered + ONE);
   assign beat_mask = MSB_FIRST ? reverse_bits(lowest) : lowest;
   assign beat_last = (residual & ~beat_mask) == '0;

   // Binary index of the isolated one-hot bit; stays 0 for an empty residual.
   always_comb begin
      beat_idx = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (beat_mask[i]) begin
            beat_idx = IDX_W'(i);
         end
      end
   end

   assign beat_valid = (state == EMIT);
   assign transfer   = beat_valid && bus.bit_ready_i;
   assign accept     = bus.data_val_i && bus.data_ready_o;

   assign bus.bit_val_o    = beat_valid;
   assign bus.bit_mask_o   = beat_valid ? beat_mask : '0;
   assign bus.bit_idx_o    = beat_valid ? beat_idx : '0;
   assign bus.bit_last_o   = beat_valid && beat_last;
   assign bus.bit_empty_o  = beat_valid && empty_q;
   assign bus.data_ready_o = !srst_i && ((state == IDLE) || (transfer && beat_last));

   // Next state: a new word always wins (it can land on the same edge as the
   // previous word's last beat); otherwise a transferred beat is cleared from
   // the residual, and the last one returns the block to IDLE.
   always_comb begin
      state_next    = state;
      residual_next = residual;
      empty_next    = empty_q;
      if (accept) begin
         state_next    = EMIT;
         residual_next = bus.data_i;
         empty_next    = (bus.data_i == '0);
      end else if (transfer) begin
         if (beat_last) begin
            state_next    = IDLE;
            residual_next = '0;
            empty_next    = 1'b0;
         end else begin
            residual_next = residual & ~beat_mask;
         end
      end
   end

   // State, residual and empty-word flag registers; reset drops any word in flight.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state    <= IDLE;
         residual <= '0;
         empty_q  <= 1'b0;
      end else begin
         state    <= state_next;
         residual <= residual_next;
         empty_q  <= empty_next;
      end
   end

endmodule

// File: tb/tb_set_bit_serializer.sv
// Bench for set_bit_serializer: one LSB-first and one MSB-first instance share
// the same stimulus. A word-level model (queue of accepted words plus the
// count of beats already taken) predicts every beat; directed scenarios also
// pin literal beat sequences.
module tb_set_bit_serializer;

   localparam int DATA_W = 16;
   localparam int IDX_W  = 4;

   logic              clk = 1'b0;
   logic              srst = 1'b1;
   logic [DATA_W-1:0] data = '0;
   logic              data_val = 1'b0;
   logic              bit_ready = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Clock generation
   always #5 clk = ~clk;

   set_bit_serializer_if #(.DATA_W(DATA_W)) if_lsb ();
   set_bit_serializer_if #(.DATA_W(DATA_W)) if_msb ();

   assign if_lsb.data_i      = data;
   assign if_lsb.data_val_i  = data_val;
   assign if_lsb.bit_ready_i = bit_ready;
   assign if_msb.data_i      = data;
   assign if_msb.data_val_i  = data_val;
   assign if_msb.bit_ready_i = bit_ready;

   set_bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1'b0)) u_lsb (
      .clk_i (clk),
      .srst_i(srst),
      .bus   (if_lsb)
   );

   set_bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1'b1)) u_msb (
      .clk_i (clk),
      .srst_i(srst),
      .bus   (if_msb)
   );

   // Reference model state
   logic [DATA_W-1:0] word_q[$];
   int                beat_k = 0;
   bit                after_reset = 1'b0;

   // Transfer log (DUT values) for literal checks
   int log_lsb[$];
   int log_msb[$];
   int log_cyc[$];
   bit log_last[$];
   bit log_empty[$];

   function automatic int popcnt(logic [DATA_W-1:0] w);
      int n = 0;
      for (int j = 0; j < DATA_W; j++) n += int'(w[j]);
      return n;
   endfunction

   function automatic int beats_of(logic [DATA_W-1:0] w);
      return (popcnt(w) == 0) ? 1 : popcnt(w);
   endfunction

   // Index of the k-th set bit, counted from bit 0 upward or from the top down
   function automatic int nth_set(logic [DATA_W-1:0] w, int k, bit msb);
      int n = 0;
      for (int j = 0; j < DATA_W; j++) begin
         int p;
         p = msb ? (DATA_W - 1 - j) : j;
         if (w[p]) begin
            if (n == k) return p;
            n++;
         end
      end
      return 0;
   endfunction

   function automatic bit model_ready();
      return !srst && (word_q.size() == 0 ||
                       (bit_ready && beat_k == beats_of(word_q[0]) - 1));
   endfunction

   // Model update on each rising edge from the (stable) bench-driven inputs
   always @(posedge clk) begin
      bit acc;
      acc = data_val && model_ready();
      cyc++;
      after_reset = srst;
      if (srst) begin
         word_q.delete();
         beat_k = 0;
      end else begin
         if (word_q.size() != 0 && bit_ready) begin
            if (beat_k == beats_of(word_q[0]) - 1) begin
               void'(word_q.pop_front());
               beat_k = 0;
            end else begin
               beat_k++;
            end
         end
         if (acc) word_q.push_back(data);
      end
   end

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
   endtask

   task automatic compareBeat(string tag, bit msb, logic val, logic rdy,
                              logic [DATA_W-1:0] mask, logic [IDX_W-1:0] idx,
                              logic last, logic empty);
      bit                exp_val;
      int                ei;
      logic [DATA_W-1:0] em;
      exp_val = (word_q.size() != 0);
      checkOutput({tag, " val"}, 32'(val), 32'(exp_val));
      checkOutput({tag, " ready"}, 32'(rdy), 32'(model_ready()));
      if (after_reset) begin
         checkOutput({tag, " reset mask"}, 32'(mask), 32'h0);
         checkOutput({tag, " reset idx"}, 32'(idx), 32'h0);
         checkOutput({tag, " reset last"}, 32'(last), 32'h0);
         checkOutput({tag, " reset empty"}, 32'(empty), 32'h0);
      end
      if (exp_val && val === 1'b1) begin
         if (word_q[0] == '0) begin
            ei = 0;
            em = '0;
         end else begin
            ei = nth_set(word_q[0], beat_k, msb);
            em = '0;
            em[ei] = 1'b1;
         end
         checkOutput({tag, " mask"}, 32'(mask), 32'(em));
         checkOutput({tag, " idx"}, 32'(idx), 32'(ei));
         checkOutput({tag, " last"}, 32'(last), 32'(beat_k == beats_of(word_q[0]) - 1));
         checkOutput({tag, " empty"}, 32'(empty), 32'(word_q[0] == '0));
      end
   endtask

   // Compare process: both DUTs against the model on every falling edge
   always @(negedge clk) begin
      compareBeat("lsb", 1'b0, if_lsb.bit_val_o, if_lsb.data_ready_o, if_lsb.bit_mask_o,
                  if_lsb.bit_idx_o, if_lsb.bit_last_o, if_lsb.bit_empty_o);
      compareBeat("msb", 1'b1, if_msb.bit_val_o, if_msb.data_ready_o, if_msb.bit_mask_o,
                  if_msb.bit_idx_o, if_msb.bit_last_o, if_msb.bit_empty_o);
      if (if_lsb.bit_val_o && bit_ready && !srst) begin
         log_lsb.push_back(int'(if_lsb.bit_idx_o));
         log_msb.push_back(int'(if_msb.bit_idx_o));
         log_cyc.push_back(cyc);
         log_last.push_back(if_lsb.bit_last_o);
         log_empty.push_back(if_lsb.bit_empty_o);
      end
   end

   task automatic clearLog();
      log_lsb.delete();
      log_msb.delete();
      log_cyc.delete();
      log_last.delete();
      log_empty.delete();
   endtask

   task automatic waitCycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one word and hold it until accepted (bounded wait)
   task automatic applyStimulus(logic [DATA_W-1:0] word);
      bit got = 1'b0;
      data     = word;
      data_val = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (if_lsb.data_ready_o === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      data_val = 1'b0;
      data     = DATA_W'($urandom);
      if (!got) begin
         n_checks++;
         $display("[TB] FAIL accept timeout: word %0h never accepted", word);
      end
   endtask

   task automatic checkConsecutive(string name);
      if (log_cyc.size() > 0)
         checkOutput(name, 32'(log_cyc[log_cyc.size()-1] - log_cyc[0]), 32'(log_cyc.size() - 1));
   endtask

   initial begin
      srst = 1'b1;
      waitCycles(3);
      srst = 1'b0;
      bit_ready = 1'b1;
      waitCycles(2);

      // 16'hA005, ready held high
      clearLog();
      applyStimulus(16'hA005);
      waitCycles(6);
      checkOutput("A005 beats", 32'(log_lsb.size()), 32'd4);
      if (log_lsb.size() == 4) begin
         checkOutput("A005 lsb idx0", 32'(log_lsb[0]), 32'd0);
         checkOutput("A005 lsb idx1", 32'(log_lsb[1]), 32'd2);
         checkOutput("A005 lsb idx2", 32'(log_lsb[2]), 32'd13);
         checkOutput("A005 lsb idx3", 32'(log_lsb[3]), 32'd15);
         checkOutput("A005 msb idx0", 32'(log_msb[0]), 32'd15);
         checkOutput("A005 msb idx1", 32'(log_msb[1]), 32'd13);
         checkOutput("A005 msb idx2", 32'(log_msb[2]), 32'd2);
         checkOutput("A005 msb idx3", 32'(log_msb[3]), 32'd0);
         checkOutput("A005 last2", 32'(log_last[2]), 32'd0);
         checkOutput("A005 last3", 32'(log_last[3]), 32'd1);
         checkConsecutive("A005 consecutive");
      end

      // Zero word, then next word accepted on the empty beat's transfer
      clearLog();
      applyStimulus(16'h0000);
      applyStimulus(16'h0003);
      waitCycles(4);
      checkOutput("zero beats", 32'(log_lsb.size()), 32'd3);
      if (log_lsb.size() == 3) begin
         checkOutput("zero empty", 32'(log_empty[0]), 32'd1);
         checkOutput("zero last", 32'(log_last[0]), 32'd1);
         checkOutput("zero idx", 32'(log_lsb[0]), 32'd0);
         checkOutput("0003 msb idx", 32'(log_msb[1]), 32'd1);
         checkConsecutive("zero no bubble");
      end

      // 16'h0011 with ready low for 3 cycles after the first beat appears
      clearLog();
      applyStimulus(16'h0011);
      bit_ready = 1'b0;
      waitCycles(3);
      bit_ready = 1'b1;
      waitCycles(3);
      checkOutput("0011 beats", 32'(log_lsb.size()), 32'd2);
      if (log_lsb.size() == 2) begin
         checkOutput("0011 idx0", 32'(log_lsb[0]), 32'd0);
         checkOutput("0011 idx1", 32'(log_lsb[1]), 32'd4);
         checkOutput("0011 last0", 32'(log_last[0]), 32'd0);
         checkOutput("0011 last1", 32'(log_last[1]), 32'd1);
      end

      // Back-to-back 16'hFFFF then 16'h0100
      clearLog();
      applyStimulus(16'hFFFF);
      applyStimulus(16'h0100);
      waitCycles(3);
      checkOutput("FFFF beats", 32'(log_lsb.size()), 32'd17);
      if (log_lsb.size() == 17) begin
         for (int i = 0; i < 16; i++) begin
            checkOutput("FFFF lsb idx", 32'(log_lsb[i]), 32'(i));
            checkOutput("FFFF msb idx", 32'(log_msb[i]), 32'(15 - i));
         end
         checkOutput("0100 idx", 32'(log_lsb[16]), 32'd8);
         checkOutput("0100 last", 32'(log_last[16]), 32'd1);
         checkConsecutive("FFFF consecutive");
      end

      // 16'h00F0 with reset after the second beat transfers
      clearLog();
      applyStimulus(16'h00F0);
      waitCycles(2);
      srst = 1'b1;
      waitCycles(1);
      srst = 1'b0;
      waitCycles(3);
      checkOutput("00F0 beats", 32'(log_lsb.size()), 32'd2);
      if (log_lsb.size() == 2) begin
         checkOutput("00F0 idx0", 32'(log_lsb[0]), 32'd4);
         checkOutput("00F0 idx1", 32'(log_lsb[1]), 32'd5);
      end
      applyStimulus(16'h0002);
      waitCycles(3);
      checkOutput("0002 beats", 32'(log_lsb.size()), 32'd3);
      if (log_lsb.size() == 3) begin
         checkOutput("0002 idx", 32'(log_lsb[2]), 32'd1);
         checkOutput("0002 last", 32'(log_last[2]), 32'd1);
      end

      // Randomized traffic with back-pressure, sparse words and rare resets
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0: data = '0;
            1: data = DATA_W'(1) << $urandom_range(0, DATA_W - 1);
            2: data = DATA_W'($urandom) & DATA_W'($urandom);
            default: data = DATA_W'($urandom);
         endcase
         data_val  = ($urandom_range(0, 2) != 0);
         bit_ready = ($urandom_range(0, 3) != 0);
         srst      = ($urandom_range(0, 299) == 0);
         waitCycles(1);
      end
      srst      = 1'b0;
      data_val  = 1'b0;
      bit_ready = 1'b1;
      waitCycles(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
